fmap_stream_tx: RTL and testbench
=================================

Name: fmap_stream_tx

Overview:
- Transmit side of the 3-channel pooled feature-map stream consumed by the second convolution layer.
- Holds one WIDTH x HEIGHT x 3 feature map in internal RAM, loaded through a simple write port.
- On a start pulse, replays the map in raster order as a valid-qualified stream: three parallel DATA_BITS channels, one pixel per cycle.
- Used to drive conv2 from stored or processor-supplied data, and as the frame source for layer-level bring-up.

Parameters:
WIDTH, 12, pixels per row
HEIGHT, 12, rows per frame
DATA_BITS, 12, bits per channel sample
ROW_GAP, 2, idle cycles inserted after each row (used only with FMAP_ROW_GAP_EN)

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write strobe for feature-map RAM
wr_addr  in  ADDR_W (clog2(WIDTH*HEIGHT)=8)  pixel address, row*WIDTH+col
wr_data  in  3*DATA_BITS  {ch3,ch2,ch1} sample
start  in  1  single-cycle frame start request
busy  out  1  frame transmission in progress
done  out  1  one-cycle pulse after last pixel sent
wr_drop  out  1  one-cycle pulse: write rejected because busy
data_out_1  out  DATA_BITS  channel 1 sample
data_out_2  out  DATA_BITS  channel 2 sample
data_out_3  out  DATA_BITS  channel 3 sample
valid_out  out  1  data_out_* valid this cycle

Behaviour:
- Reset is asynchronous and active-low. While reset is asserted, all outputs are 0, the FSM is in IDLE and the counters are 0. RAM contents are not reset and are preserved.
- FSM states:
  - IDLE: start=1 moves to READ. start is ignored in every other state.
  - READ: issues the RAM read at addr = row*WIDTH+col. col increments each cycle; at col=WIDTH-1 it wraps to 0 and row increments. After issuing the pixel at (HEIGHT-1, WIDTH-1), moves to FLUSH.
  - FLUSH: one cycle that lets the last read emerge, then moves to DONE.
  - DONE: done=1 for exactly one cycle, then back to IDLE.
- RAM read latency is 1 cycle. valid_out is the read-issue flag registered one cycle. data_out_* are registered RAM outputs, forced to 0 whenever valid_out=0.
- Timing, with start sampled at edge T:
  - busy=1 from T+1 through the DONE cycle inclusive.
  - First valid_out at T+2.
  - WIDTH*HEIGHT=144 contiguous valid cycles (T+2..T+145).
  - done at T+146, busy=0 from T+147.
  - A new start is accepted at the earliest at T+147 (IDLE).
- Write port:
  - Writes are accepted only when busy=0, and complete on the same edge.
  - wr_en while busy=1: the write is discarded and wr_drop pulses on the next cycle.
  - wr_addr >= WIDTH*HEIGHT: ignored, no wr_drop.
  - Read-after-write in IDLE: data written at edge N is visible to a frame started at edge N or later.
- Channel mapping: data_out_1 = wr_data[DATA_BITS-1:0], data_out_2 = the next slice, data_out_3 = the top slice. No arithmetic; samples pass through bit-exact.
- Reset mid-frame: abort immediately. valid_out/busy drop asynchronously, no done pulse. The next start retransmits from pixel 0.

Optional Feature:
FMAP_ROW_GAP_EN
- Defined:
  - After the last pixel of each row except the final row, the FSM enters a GAP state for ROW_GAP cycles.
  - No read is issued and valid_out=0 during GAP.
  - Frame length becomes 144+(HEIGHT-1)*ROW_GAP valid-window cycles, so done moves to T+146+(HEIGHT-1)*ROW_GAP. With defaults that is T+168.
  - Purpose: exercises downstream line-buffer tolerance of non-contiguous valid.
- Undefined: the GAP state and its counter are not built, and the stream is fully contiguous.

Decomposition:
- Shared package cnn_pkg holds:
  - FMAP_W=12, FMAP_H=12, FMAP_DATA_BITS=12
  - ADDR_W derived via clog2
  - FSM state encoding: IDLE, READ, GAP, FLUSH, DONE
- Sub-module fmap_ram: simple dual-port synchronous RAM, depth WIDTH*HEIGHT, width 3*DATA_BITS, 1-cycle registered read, no reset.
- fmap_stream_tx holds the FSM, row/col counters, output registers and the write gating.

Test Plan:
- Load ram[i] = {i+2, i+1, i} for i=0..143, pulse start at T:
  - valid_out high exactly T+2..T+145.
  - At T+2+i: data_out_1=i, data_out_2=i+1, data_out_3=i+2.
  - done only at T+146, busy high T+1..T+146.
- start re-pulsed at T+10 and on the done cycle: both ignored, still exactly 144 valid pixels. A start at T+147 launches a second identical frame.
- wr_en at T+50 (addr 5, data 0xFFF_FFF_FFF): wr_drop=1 at T+51, and the next frame still outputs pixel 5 as {7,6,5}.
- rst_n low at T+80 for 3 cycles: valid_out/busy/data 0 immediately, no done. Restarting outputs pixel 0 = {2,1,0} at its first valid cycle.
- Write addr 200: no effect and no wr_drop. Write addr 143 = 0x123_456_789 in IDLE then start: the last pixel reads 0x789/0x456/0x123.
- With FMAP_ROW_GAP_EN:
  - valid low for exactly 2 cycles after pixels 11, 23, ..., 131.
  - 144 valid pixels total, done at T+168.

Source files
------------

// File: rtl/cnn_pkg.sv
// ============================================================================
// Module  : cnn_pkg
// Brief   : Shared feature-map geometry and stream-transmitter FSM encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cnn_pkg;

    localparam int FMAP_W         = 12;
    localparam int FMAP_H         = 12;
    localparam int FMAP_DATA_BITS = 12;
    localparam int FMAP_ROW_GAP   = 2;
    localparam int FMAP_ADDR_W    = $clog2(FMAP_W * FMAP_H);

    localparam int ST_W = 3;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_GAP   = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

`default_nettype wire

// File: rtl/fmap_ram.sv
// ============================================================================
// Module  : fmap_ram
// Brief   : Simple dual-port synchronous RAM, registered 1-cycle read, no reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fmap_ram #(
    parameter int DEPTH  = 144,
    parameter int DATA_W = 36,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/fmap_stream_tx.sv
// ============================================================================
// Module  : fmap_stream_tx
// Brief   : Stores one WIDTH x HEIGHT x 3 feature map and replays it in raster
//           order as a valid-qualified 3-channel stream on each start pulse.
//           Optional macro FMAP_ROW_GAP_EN inserts ROW_GAP idle cycles per row.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fmap_stream_tx
    import cnn_pkg::*;
#(
    parameter  int WIDTH     = FMAP_W,
    parameter  int HEIGHT    = FMAP_H,
    parameter  int DATA_BITS = FMAP_DATA_BITS,
    parameter  int ROW_GAP   = FMAP_ROW_GAP,
    localparam int ADDR_W    = $clog2(WIDTH * HEIGHT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [3*DATA_BITS-1:0] wr_data,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   wr_drop,
    output logic [DATA_BITS-1:0]   data_out_1,
    output logic [DATA_BITS-1:0]   data_out_2,
    output logic [DATA_BITS-1:0]   data_out_3,
    output logic                   valid_out
);

    localparam int NPIX  = WIDTH * HEIGHT;
    localparam int DW    = 3 * DATA_BITS;
    localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    if (ROW_GAP < 1) begin : g_row_gap_check
        $error("ROW_GAP must be at least 1");
    end

    logic [ST_W-1:0]   state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              valid_q, valid_d;
    logic              wr_drop_q, wr_drop_d;

    logic              last_col;
    logic              last_row;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DW-1:0]     rd_data;
    logic              wr_addr_ok;
    logic              ram_we;

`ifdef FMAP_ROW_GAP_EN
    localparam int GAP_W = (ROW_GAP > 1) ? $clog2(ROW_GAP) : 1;
    logic [GAP_W-1:0] gap_q, gap_d;
`endif

    assign last_col = (col_q == COL_W'(WIDTH - 1));
    assign last_row = (row_q == ROW_W'(HEIGHT - 1));
    assign rd_en    = (state_q == ST_READ);
    assign rd_addr  = ADDR_W'(row_q) * ADDR_W'(WIDTH) + ADDR_W'(col_q);

    // Extra bit so a power-of-two pixel count still compares correctly.
    assign wr_addr_ok = ({1'b0, wr_addr} < (ADDR_W + 1)'(NPIX));
    assign ram_we     = wr_en & ~busy & wr_addr_ok;

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
`ifdef FMAP_ROW_GAP_EN
        gap_d     = gap_q;
`endif
        valid_d   = rd_en;
        wr_drop_d = wr_en & busy & wr_addr_ok;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            ST_READ: begin
                if (last_col) begin
                    col_d = '0;
                    if (last_row) begin
                        state_d = ST_FLUSH;
                    end else begin
                        row_d = row_q + 1'b1;
`ifdef FMAP_ROW_GAP_EN
                        state_d = ST_GAP;
                        gap_d   = '0;
`endif
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
`ifdef FMAP_ROW_GAP_EN
            ST_GAP: begin
                if (gap_q == GAP_W'(ROW_GAP - 1)) begin
                    state_d = ST_READ;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
`endif
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            valid_q   <= 1'b0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            valid_q   <= valid_d;
            wr_drop_q <= wr_drop_d;
        end
    end

`ifdef FMAP_ROW_GAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end
`endif

    fmap_ram #(
        .DEPTH  (NPIX),
        .DATA_W (DW),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_addr),
        .wdata (wr_data),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign wr_drop   = wr_drop_q;
    assign valid_out = valid_q;

    // RAM output register holds stale data between frames; blank it here.
    assign data_out_1 = valid_q ? rd_data[DATA_BITS-1:0]             : '0;
    assign data_out_2 = valid_q ? rd_data[2*DATA_BITS-1:DATA_BITS]   : '0;
    assign data_out_3 = valid_q ? rd_data[3*DATA_BITS-1:2*DATA_BITS] : '0;

endmodule

`default_nettype wire

// File: tb/tb_fmap_stream_tx.sv
// ============================================================================
// Module  : tb_fmap_stream_tx
// Brief   : Self-checking bench for fmap_stream_tx against a pixel-schedule model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fmap_stream_tx;

    localparam int W    = 12;
    localparam int H    = 12;
    localparam int DB   = 12;
    localparam int NPIX = W * H;
`ifdef FMAP_ROW_GAP_EN
    localparam int GAP = 2;
`else
    localparam int GAP = 0;
`endif
    localparam int DONE_K = 2 + NPIX + GAP * (H - 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_addr = '0;
    logic [35:0]   wr_data = '0;
    logic          start = 1'b0;
    logic          busy, done, wr_drop, valid_out;
    logic [DB-1:0] data_out_1, data_out_2, data_out_3;

    int n_cmp = 0;
    int n_bad = 0;
    logic [35:0] mem_model [NPIX];

    always #5 clk = ~clk;

    fmap_stream_tx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .wr_drop    (wr_drop),
        .data_out_1 (data_out_1),
        .data_out_2 (data_out_2),
        .data_out_3 (data_out_3),
        .valid_out  (valid_out)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Idle-time write; the model only keeps in-range addresses.
    task automatic write_px(input logic [7:0] a, input logic [35:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
        if (int'(a) < NPIX) mem_model[int'(a)] = d;
        n_cmp++;
        if (wr_drop !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_wr_drop addr=%0d got=%b want=0", a, wr_drop);
        end
    endtask

    // Runs one frame cycle by cycle. Cycle k=1 is the first cycle after the
    // edge that sampled start; pixel p is expected at 2+p+GAP*(p/W).
    task automatic run_frame(input bit pre_started, input int extra_k, input bit start_on_done,
                             input int wr_k, input logic [7:0] wa, input logic [35:0] wd,
                             input int rst_k, input bit chain);
        int          pix_at [DONE_K + 2];
        logic        exp_v;
        logic [35:0] exp_d, got_d;
        for (int c = 0; c < DONE_K + 2; c++) pix_at[c] = -1;
        for (int p = 0; p < NPIX; p++) pix_at[2 + p + GAP * (p / W)] = p;
        if (!pre_started) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        for (int k = 1; k <= DONE_K + 1; k++) begin
            if (k == rst_k) begin
                rst_n = 1'b0;
                #1;
                got_d = {data_out_3, data_out_2, data_out_1};
                n_cmp++;
                if ({busy, valid_out, done, wr_drop} !== 4'b0 || got_d !== 36'd0) begin
                    n_bad++;
                    $display("FAIL rst_abort k=%0d busy/valid/done/drop=%b%b%b%b data=%h want all 0",
                             k, busy, valid_out, done, wr_drop, got_d);
                end
                repeat (3) tick();
                rst_n = 1'b1;
                for (int j = 0; j < 4; j++) begin
                    tick();
                    n_cmp++;
                    if ({busy, valid_out, done} !== 3'b0) begin
                        n_bad++;
                        $display("FAIL post_rst_idle j=%0d busy/valid/done=%b%b%b want 000",
                                 j, busy, valid_out, done);
                    end
                end
                return;
            end
            exp_v = (pix_at[k] >= 0);
            exp_d = exp_v ? mem_model[pix_at[k]] : 36'd0;
            got_d = {data_out_3, data_out_2, data_out_1};
            n_cmp++;
            if (valid_out !== exp_v) begin
                n_bad++;
                $display("FAIL valid k=%0d got=%b want=%b", k, valid_out, exp_v);
            end
            n_cmp++;
            if (got_d !== exp_d) begin
                n_bad++;
                $display("FAIL data k=%0d got=%h want=%h", k, got_d, exp_d);
            end
            n_cmp++;
            if (busy !== (k <= DONE_K)) begin
                n_bad++;
                $display("FAIL busy k=%0d got=%b want=%b", k, busy, (k <= DONE_K));
            end
            n_cmp++;
            if (done !== (k == DONE_K)) begin
                n_bad++;
                $display("FAIL done k=%0d got=%b want=%b", k, done, (k == DONE_K));
            end
            n_cmp++;
            if (wr_drop !== (wr_k > 0 && k == wr_k + 1)) begin
                n_bad++;
                $display("FAIL wr_drop k=%0d got=%b want=%b", k, wr_drop, (wr_k > 0 && k == wr_k + 1));
            end
            start   = (k == extra_k) || (start_on_done && k == DONE_K) || (chain && k == DONE_K + 1);
            wr_en   = (k == wr_k);
            wr_addr = wa;
            wr_data = wd;
            tick();
            wr_en = 1'b0;
            start = 1'b0;
        end
    endtask

    task automatic test_reset;
        repeat (3) tick();
        for (int j = 0; j < 2; j++) begin
            n_cmp++;
            if ({busy, done, wr_drop, valid_out, data_out_1, data_out_2, data_out_3} !== '0) begin
                n_bad++;
                $display("FAIL reset_state busy/done/drop/valid=%b%b%b%b data=%h%h%h want 0",
                         busy, done, wr_drop, valid_out, data_out_3, data_out_2, data_out_1);
            end
            tick();
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if ({busy, valid_out} !== 2'b0) begin
            n_bad++;
            $display("FAIL reset_release busy/valid=%b%b want 00", busy, valid_out);
        end
    endtask

    task automatic test_pattern_frame;
        for (int i = 0; i < NPIX; i++) write_px(8'(i), {12'(i + 2), 12'(i + 1), 12'(i)});
        run_frame(1'b0, 0, 1'b0, 0, 8'd0, 36'd0, 0, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_frame(1'b0, 10, 1'b1, 0, 8'd0, 36'd0, 0, 1'b1);
        run_frame(1'b1, 0, 1'b0, 0, 8'd0, 36'd0, 0, 1'b0);
    endtask

    task automatic test_write_drop;
        run_frame(1'b0, 0, 1'b0, 50, 8'd5, 36'hFFF_FFF_FFF, 0, 1'b1);
        run_frame(1'b1, 0, 1'b0, 0, 8'd0, 36'd0, 0, 1'b0);
    endtask

    task automatic test_reset_midframe;
        run_frame(1'b0, 0, 1'b0, 0, 8'd0, 36'd0, 80, 1'b0);
        run_frame(1'b0, 0, 1'b0, 0, 8'd0, 36'd0, 0, 1'b0);
    endtask

    task automatic test_addr_boundary;
        write_px(8'd200, 36'hABC_DEF_012);
        write_px(8'd143, 36'h123_456_789);
        run_frame(1'b0, 0, 1'b0, 0, 8'd0, 36'd0, 0, 1'b0);
    endtask

    task automatic test_random_frame;
        for (int i = 0; i < NPIX; i++) write_px(8'(i), {4'($urandom()), $urandom()});
        run_frame(1'b0, $urandom_range(3, 100), 1'b0, 0, 8'd0, 36'd0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_pattern_frame();
        test_back_to_back();
        test_write_drop();
        test_reset_midframe();
        test_addr_boundary();
        test_random_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
